// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM receive-side demultiplexer.
// Holds the lock FSM states, default sizing and channel-slice arithmetic.
package tdm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_t;

  localparam int TDM_N_CH   = 8;
  localparam int TDM_DATA_W = 1;

  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Serial sample bus in, parallel frame bus out, for tdm_demux.
// master drives samples (source side); slave is the demultiplexer.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int N_CH   = TDM_N_CH,
  parameter int DATA_W = TDM_DATA_W
);

  localparam int IDX_W = $clog2(N_CH);

  logic [DATA_W-1:0]      din;
  logic                   din_valid;
  logic                   frame_sync;
  logic [N_CH*DATA_W-1:0] dout;
  logic                   dout_valid;
  logic [IDX_W-1:0]       ch_idx;
  logic                   locked;
  logic                   frame_err;

  modport master (
    output din,
    output din_valid,
    output frame_sync,
    input  dout,
    input  dout_valid,
    input  ch_idx,
    input  locked,
    input  frame_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_sync,
    output dout,
    output dout_valid,
    output ch_idx,
    output locked,
    output frame_err
  );

endinterface

// File: rtl/tdm_demux_decoder.sv
// Index-to-one-hot write strobe for the shadow channel registers.
// Structural inverse of an N:1 selector mux.
module demux_decoder #(
  parameter  int N_CH  = 8,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_CH-1:0]  strobe
);

  always_comb begin
    strobe = '0;
    for (int k = 0; k < N_CH; k++) begin
      strobe[k] = en && (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: serial samples into a registered frame.
// Optional missing-sync check enabled by TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH   = TDM_N_CH,
  parameter  int DATA_W = TDM_DATA_W,
  localparam int IDX_W  = $clog2(N_CH),
  localparam int FW     = N_CH * DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  tdm_demux_if.slave   bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

  tdm_state_t       st, st_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [FW-1:0]    shadow, sh_n;
  logic [FW-1:0]    dout_q, do_n;
  logic             dv_q, dv_n;
  logic             fe_q, fe_n;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             clr;
  logic             drop;
  logic [N_CH-1:0]  strobe;

  demux_decoder #(.N_CH(N_CH)) u_dec (
    .idx    (wr_idx),
    .en     (wr_en),
    .strobe (strobe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= HUNT;
      idx    <= '0;
      shadow <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      st     <= st_n;
      idx    <= idx_n;
      shadow <= sh_n;
      dout_q <= do_n;
      dv_q   <= dv_n;
      fe_q   <= fe_n;
    end
  end

  // Control: decide where (and whether) this sample lands.
  always_comb begin
    st_n   = st;
    wr_en  = 1'b0;
    wr_idx = idx;
    clr    = 1'b0;
    drop   = 1'b0;
    dv_n   = 1'b0;
    fe_n   = 1'b0;
    if (bus.din_valid) begin
      unique case (st)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            clr    = 1'b1;
            st_n   = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.frame_sync && idx != '0) begin
            fe_n   = 1'b1;
            clr    = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
          end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          else if (!bus.frame_sync && idx == '0) begin
            fe_n = 1'b1;
            drop = 1'b1;
            st_n = HUNT;
          end
`endif
          else begin
            wr_en = 1'b1;
            dv_n  = (idx == LAST);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: shadow update, index advance, frame publish.
  always_comb begin
    sh_n = clr ? '0 : shadow;
    for (int k = 0; k < N_CH; k++) begin
      if (strobe[k]) begin
        sh_n[slice_off(k, DATA_W) +: DATA_W] = bus.din;
      end
    end
    idx_n = idx;
    if (wr_en) begin
      idx_n = (wr_idx == LAST) ? '0 : wr_idx + IDX_W'(1);
    end else if (drop) begin
      idx_n = '0;
    end
    do_n = dv_n ? sh_n : dout_q;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.ch_idx     = idx;
  assign bus.locked     = (st == COLLECT);
  assign bus.frame_err  = fe_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed plus randomized checks of tdm_demux against a frame-level model.
// Model tracks lock, next channel and the assembled frame as plain arrays.
module tb_tdm_demux;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  tdm_demux_if #(.N_CH(N), .DATA_W(1)) bus ();

  tdm_demux #(.N_CH(N), .DATA_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit       m_lock;
  int       m_idx;
  bit       m_buf [N];
  bit [7:0] m_dout;
  bit       m_dv;
  bit       m_fe;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0;
    m_idx  = 0;
    m_dout = '0;
    m_dv   = 0;
    m_fe   = 0;
    foreach (m_buf[k]) m_buf[k] = 0;
  endtask

  task automatic model(input bit v, input bit s, input bit d);
    m_dv = 0;
    m_fe = 0;
    if (!v) return;
    if (!m_lock) begin
      if (s) begin
        m_lock = 1;
        m_buf[0] = d;
        m_idx = 1;
      end
    end else if (s && m_idx != 0) begin
      m_fe = 1;
      foreach (m_buf[k]) m_buf[k] = 0;
      m_buf[0] = d;
      m_idx = 1;
    end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    else if (!s && m_idx == 0) begin
      m_fe = 1;
      m_lock = 0;
    end
`endif
    else begin
      m_buf[m_idx] = d;
      if (m_idx == N - 1) begin
        for (int k = 0; k < N; k++) m_dout[k] = m_buf[k];
        m_dv = 1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, 64'(bus.dout), 64'(m_dout));
    chk({tag, ".dout_valid"}, 64'(bus.dout_valid), 64'(m_dv));
    chk({tag, ".ch_idx"}, 64'(bus.ch_idx), 64'(m_idx));
    chk({tag, ".locked"}, 64'(bus.locked), 64'(m_lock));
    chk({tag, ".frame_err"}, 64'(bus.frame_err), 64'(m_fe));
  endtask

  task automatic step(input string tag, input bit v, input bit s,
                      input bit d);
    @(negedge clk);
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = d;
    @(posedge clk);
    #1;
    model(v, s, d);
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input bit [7:0] bits,
                            input int gap);
    for (int k = 0; k < N; k++) begin
      step(tag, 1'b1, k == 0, bits[k]);
      for (int g = 0; g < gap; g++) step({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Samples before any sync are ignored
    for (int i = 0; i < 3; i++) step("hunt", 1'b1, 1'b0, 1'b1);
    chk("hunt.idx", 64'(bus.ch_idx), 64'd0);
    step("lock", 1'b1, 1'b1, 1'b1);
    chk("lock.locked", 64'(bus.locked), 64'd1);
    chk("lock.idx", 64'(bus.ch_idx), 64'd1);
    for (int k = 1; k < N; k++) begin
      logic [7:0] pat;
      pat = 8'b0100_1101;
      step("frame", 1'b1, 1'b0, pat[k]);
    end
    step("frame.after", 1'b0, 1'b0, 1'b0);
    chk("frame.const", 64'(bus.dout), 64'h4D);

    // Same frame with idle gaps
    send_frame("gaps", 8'b0100_1101, 1);
    step("gaps.hold", 1'b0, 1'b0, 1'b0);

    // Early sync after four data samples
    send_frame("pre", 8'hA5, 0);
    step("es0", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) step("es.part", 1'b1, 1'b0, 1'b1);
    step("es.sync", 1'b1, 1'b1, 1'b1);
    chk("es.err", 64'(bus.frame_err), 64'd1);
    chk("es.dout", 64'(bus.dout), 64'hA5);
    for (int k = 1; k < N; k++) step("es.fill", 1'b1, 1'b0, k[0]);
    chk("es.done", 64'(bus.dout), 64'hAB);

    // Sync landing on the last channel
    send_frame("last.pre", 8'h3C, 0);
    step("last0", 1'b1, 1'b1, 1'b1);
    for (int k = 1; k < N - 1; k++) step("last.mid", 1'b1, 1'b0, 1'b1);
    step("last.sync", 1'b1, 1'b1, 1'b0);
    chk("last.nodv", 64'(bus.dout_valid), 64'd0);
    chk("last.keep", 64'(bus.dout), 64'h3C);

    // Channel-0 sample without sync after a good frame
    send_frame("ms.pre", 8'h96, 0);
    step("ms.nosync", 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < N; k++) step("ms.rest", 1'b1, 1'b0, 1'b0);
    step("ms.idle", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    send_frame("ar.pre", 8'h5A, 0);
    step("ar0", 1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) step("ar.part", 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("ar.async");
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.frame_sync = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step("ar.hunt", 1'b1, 1'b0, 1'b1);
    send_frame("ar.frame", 8'hC3, 0);
    step("ar.idle", 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit v, s, d;
      v = ($urandom_range(0, 9) < 7);
      if (m_idx == 0) s = ($urandom_range(0, 9) < 8);
      else            s = ($urandom_range(0, 29) == 0);
      d = 1'($urandom);
      step("rnd", v, s, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
